instruction_fetch_unit: RTL and testbench

//  Serves 26-bit instructions to control_matrix. Watches instructionPointer; whenever it

---
 rtl/instruction_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetches 26-bit instruction words from byte-wide program memory,
//            four big-endian beats per word, whenever instructionPointer moves.
// Options  : ILLEGAL_OPCODE_CHECK_EN adds illegalOpcode and no-op substitution.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
   parameter int ADDR_W    = 18,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       instructionPointer,
   output logic [25:0]       instruction,
   output logic              instructionValid,
   output logic              fetchBusy,
   output logic [ADDR_W-1:0] memAddress,
   output logic              memRead,
   input  logic              memReady,
   input  logic [7:0]        memData
`ifdef ILLEGAL_OPCODE_CHECK_EN
   ,
   output logic              illegalOpcode
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } state_t;

   state_t            r_state, w_nextState;
   logic [15:0]       r_fetchedIp, w_nextFetchedIp;
   logic              r_reloadPending, w_nextReloadPending;
   logic [25:0]       r_instruction, w_nextInstruction;
   logic              r_valid, w_nextValid;
   logic              r_busy, w_nextBusy;
   logic              r_memRead, w_nextMemRead;
   logic [ADDR_W-1:0] r_memAddress, w_nextMemAddress;
   logic [1:0]        r_beat, w_nextBeat;
   logic [17:0]       r_shadow, w_nextShadow;
   logic [ADDR_W-1:0] w_beat0Addr;
   logic [25:0]       w_word;
   logic              w_ipMoved;
`ifdef ILLEGAL_OPCODE_CHECK_EN
   logic              r_illegal, w_nextIllegal;
   logic              w_opcodeLegal;
`endif

   // Byte address wraps naturally modulo 2**ADDR_W through truncation.
   assign w_beat0Addr = ADDR_W'(BASE_ADDR) + ADDR_W'({instructionPointer, 2'b00});
   assign w_ipMoved   = (instructionPointer != r_fetchedIp);
   assign w_word      = {r_shadow, memData};

`ifdef ILLEGAL_OPCODE_CHECK_EN
   always_comb begin
      w_opcodeLegal = 1'b0;
      case (w_word[25:22])
         4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7: w_opcodeLegal = 1'b1;
         default:                            w_opcodeLegal = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_fetchedIp     <= '0;
         r_reloadPending <= 1'b1;
         r_instruction   <= '0;
         r_valid         <= 1'b0;
         r_busy          <= 1'b0;
         r_memRead       <= 1'b0;
         r_memAddress    <= '0;
         r_beat          <= '0;
         r_shadow        <= '0;
`ifdef ILLEGAL_OPCODE_CHECK_EN
         r_illegal       <= 1'b0;
`endif
      end else begin
         r_state         <= w_nextState;
         r_fetchedIp     <= w_nextFetchedIp;
         r_reloadPending <= w_nextReloadPending;
         r_instruction   <= w_nextInstruction;
         r_valid         <= w_nextValid;
         r_busy          <= w_nextBusy;
         r_memRead       <= w_nextMemRead;
         r_memAddress    <= w_nextMemAddress;
         r_beat          <= w_nextBeat;
         r_shadow        <= w_nextShadow;
`ifdef ILLEGAL_OPCODE_CHECK_EN
         r_illegal       <= w_nextIllegal;
`endif
      end
   end

   always_comb begin
      w_nextState         = r_state;
      w_nextFetchedIp     = r_fetchedIp;
      w_nextReloadPending = r_reloadPending;
      w_nextInstruction   = r_instruction;
      w_nextValid         = r_valid;
      w_nextBusy          = r_busy;
      w_nextMemRead       = r_memRead;
      w_nextMemAddress    = r_memAddress;
      w_nextBeat          = r_beat;
      w_nextShadow        = r_shadow;
`ifdef ILLEGAL_OPCODE_CHECK_EN
      w_nextIllegal       = r_illegal;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_ipMoved || r_reloadPending) begin
               w_nextFetchedIp     = instructionPointer;
               w_nextReloadPending = 1'b0;
               w_nextValid         = 1'b0;
               w_nextBusy          = 1'b1;
               w_nextMemRead       = 1'b1;
               w_nextBeat          = 2'd0;
               w_nextMemAddress    = w_beat0Addr;
`ifdef ILLEGAL_OPCODE_CHECK_EN
               w_nextIllegal       = 1'b0;
`endif
               w_nextState         = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (memReady) begin
               case (r_beat)
                  2'd0:    w_nextShadow[17:16] = memData[1:0];
                  2'd1:    w_nextShadow[15:8]  = memData;
                  2'd2:    w_nextShadow[7:0]   = memData;
                  default: ;
               endcase
               // A pointer move mid-fetch throws away the partial word.
               if (w_ipMoved) begin
                  w_nextFetchedIp  = instructionPointer;
                  w_nextBeat       = 2'd0;
                  w_nextMemAddress = w_beat0Addr;
               end else if (r_beat != 2'd3) begin
                  w_nextBeat       = r_beat + 2'd1;
                  w_nextMemAddress = r_memAddress + ADDR_W'(1);
               end else begin
`ifdef ILLEGAL_OPCODE_CHECK_EN
                  w_nextInstruction = w_opcodeLegal ? w_word : 26'd0;
                  w_nextIllegal     = ~w_opcodeLegal;
`else
                  w_nextInstruction = w_word;
`endif
                  w_nextValid       = 1'b1;
                  w_nextMemRead     = 1'b0;
                  w_nextBusy        = 1'b0;
                  w_nextState       = ST_IDLE;
               end
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   assign instruction      = r_instruction;
   assign instructionValid = r_valid;
   assign fetchBusy        = r_busy;
   assign memAddress       = r_memAddress;
   assign memRead          = r_memRead;
`ifdef ILLEGAL_OPCODE_CHECK_EN
   assign illegalOpcode    = r_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// Directed bench for instruction_fetch_unit with a byte-wide memory model
// (ADDR_W=10 so the address wrap case is reachable).
module tb_instruction_fetch_unit;
   localparam int ADDR_W = 10;
   localparam logic [25:0] WORD_A = 26'h3113865;  // mem 000..003
   localparam logic [25:0] WORD_B = 26'h05AC37E;  // mem 004..007
   localparam logic [25:0] WORD_C = 26'h1C41234;  // mem 008..00B
   localparam logic [25:0] WORD_I = 26'h1000000;  // mem 00C..00F, opcode 0100
   localparam logic [25:0] WORD_D = 26'h0C055AA;  // mem 3FC..3FF

   logic              clock = 1'b0;
   logic              reset;
   logic [15:0]       instructionPointer;
   logic [25:0]       instruction;
   logic              instructionValid;
   logic              fetchBusy;
   logic [ADDR_W-1:0] memAddress;
   logic              memRead;
   logic              memReady;
   logic [7:0]        memData;
`ifdef ILLEGAL_OPCODE_CHECK_EN
   logic              illegalOpcode;
`endif
   logic [7:0]        mem [0:1023];

   int checkCount = 0;
   int passCount  = 0;

   instruction_fetch_unit #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clock              (clock),
      .reset              (reset),
      .instructionPointer (instructionPointer),
      .instruction        (instruction),
      .instructionValid   (instructionValid),
      .fetchBusy          (fetchBusy),
      .memAddress         (memAddress),
      .memRead            (memRead),
      .memReady           (memReady),
      .memData            (memData)
`ifdef ILLEGAL_OPCODE_CHECK_EN
      ,
      .illegalOpcode      (illegalOpcode)
`endif
   );

   assign memData = mem[memAddress];
   always #5 clock = ~clock;

   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [25:0] expWord(input logic [25:0] w);
`ifdef ILLEGAL_OPCODE_CHECK_EN
      case (w[25:22])
         4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7: return w;
         default:                            return 26'd0;
      endcase
`else
      return w;
`endif
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      {mem[0],  mem[1],  mem[2],  mem[3]}  = {8'h03, 8'h11, 8'h38, 8'h65};
      {mem[4],  mem[5],  mem[6],  mem[7]}  = {8'hFC, 8'h5A, 8'hC3, 8'h7E};
      {mem[8],  mem[9],  mem[10], mem[11]} = {8'hA9, 8'hC4, 8'h12, 8'h34};
      {mem[12], mem[13], mem[14], mem[15]} = {8'h01, 8'h00, 8'h00, 8'h00};
      {mem[1020], mem[1021], mem[1022], mem[1023]} = {8'hF0, 8'hC0, 8'h55, 8'hAA};

      reset = 1'b1;
      memReady = 1'b1;
      instructionPointer = 16'd0;
      tick(2);
      checkValue("rst_instruction", 32'(instruction), 32'd0);
      checkValue("rst_valid",       32'(instructionValid), 32'd0);
      checkValue("rst_busy",        32'(fetchBusy), 32'd0);
      checkValue("rst_memRead",     32'(memRead), 32'd0);
      checkValue("rst_memAddress",  32'(memAddress), 32'd0);

      // Reload after reset, zero-wait memory
      reset = 1'b0;
      tick(1);
      checkValue("t1_start_memRead", 32'(memRead), 32'd1);
      tick(3);
      checkValue("t1_edge4_addr",  32'(memAddress), 32'h3);
      checkValue("t1_edge4_valid", 32'(instructionValid), 32'd0);
      tick(1);
      checkValue("t1_valid", 32'(instructionValid), 32'd1);
      checkValue("t1_word",  32'(instruction), 32'(expWord(WORD_A)));
      checkValue("t1_busy",  32'(fetchBusy), 32'd0);
      checkValue("t1_memRead_drop", 32'(memRead), 32'd0);

      // Wait states on beat 2
      instructionPointer = 16'd1;
      tick(1);
      checkValue("t2_addr_a", 32'(memAddress), 32'h4);
      checkValue("t2_hold_word", 32'(instruction), 32'(expWord(WORD_A)));
      tick(1);
      checkValue("t2_addr_b", 32'(memAddress), 32'h5);
      tick(1);
      checkValue("t2_addr_c", 32'(memAddress), 32'h6);
      memReady = 1'b0;
      tick(1);
      checkValue("t2_addr_d", 32'(memAddress), 32'h6);
      checkValue("t2_read_held", 32'(memRead), 32'd1);
      tick(1);
      checkValue("t2_addr_e", 32'(memAddress), 32'h6);
      memReady = 1'b1;
      tick(1);
      checkValue("t2_addr_f",  32'(memAddress), 32'h7);
      checkValue("t2_valid_f", 32'(instructionValid), 32'd0);
      tick(1);
      checkValue("t2_valid", 32'(instructionValid), 32'd1);
      checkValue("t2_word",  32'(instruction), 32'(expWord(WORD_B)));

      // Word with opcode 0100
      instructionPointer = 16'd3;
      tick(5);
      checkValue("t6_valid", 32'(instructionValid), 32'd1);
      checkValue("t6_word",  32'(instruction), 32'(expWord(WORD_I)));
`ifdef ILLEGAL_OPCODE_CHECK_EN
      checkValue("t6_illegal", 32'(illegalOpcode), 32'd1);
`endif

      // IP moves 1 -> 2 while beat 1 is outstanding
      instructionPointer = 16'd1;
      tick(1);
`ifdef ILLEGAL_OPCODE_CHECK_EN
      checkValue("t6_illegal_clear", 32'(illegalOpcode), 32'd0);
`endif
      tick(1);
      checkValue("t3_beat1_addr", 32'(memAddress), 32'h5);
      instructionPointer = 16'd2;
      tick(1);
      checkValue("t3_restart_addr", 32'(memAddress), 32'h8);
      checkValue("t3_valid_low",    32'(instructionValid), 32'd0);
      checkValue("t3_hold_word",    32'(instruction), 32'(expWord(WORD_I)));
      tick(3);
      checkValue("t3_last_addr", 32'(memAddress), 32'hB);
      checkValue("t3_not_yet",   32'(instructionValid), 32'd0);
      tick(1);
      checkValue("t3_valid", 32'(instructionValid), 32'd1);
      checkValue("t3_word",  32'(instruction), 32'(expWord(WORD_C)));

      // Stable IP: no traffic
      tick(5);
      checkValue("idle_memRead", 32'(memRead), 32'd0);
      checkValue("idle_valid",   32'(instructionValid), 32'd1);
      checkValue("idle_busy",    32'(fetchBusy), 32'd0);

      // Top of address space and wrap
      instructionPointer = 16'h00FF;
      tick(1);
      checkValue("t5_addr_3fc", 32'(memAddress), 32'h3FC);
      tick(3);
      checkValue("t5_addr_3ff", 32'(memAddress), 32'h3FF);
      tick(1);
      checkValue("t5_word", 32'(instruction), 32'(expWord(WORD_D)));
      instructionPointer = 16'h0100;
      tick(1);
      checkValue("t5_wrap_addr", 32'(memAddress), 32'h000);
      tick(4);
      checkValue("t5_wrap_valid", 32'(instructionValid), 32'd1);
      checkValue("t5_wrap_word",  32'(instruction), 32'(expWord(WORD_A)));

      // Async reset during beat 2
      instructionPointer = 16'd1;
      tick(3);
      checkValue("t4_beat2_addr", 32'(memAddress), 32'h6);
      #2 reset = 1'b1;
      #1;
      checkValue("t4_rst_instruction", 32'(instruction), 32'd0);
      checkValue("t4_rst_valid",       32'(instructionValid), 32'd0);
      checkValue("t4_rst_busy",        32'(fetchBusy), 32'd0);
      checkValue("t4_rst_memRead",     32'(memRead), 32'd0);
      checkValue("t4_rst_addr",        32'(memAddress), 32'd0);
      tick(1);
      reset = 1'b0;
      tick(1);
      checkValue("t4_restart_addr", 32'(memAddress), 32'h4);
      checkValue("t4_restart_busy", 32'(fetchBusy), 32'd1);
      tick(4);
      checkValue("t4_valid", 32'(instructionValid), 32'd1);
      checkValue("t4_word",  32'(instruction), 32'(expWord(WORD_B)));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
`default_nettype wire
